// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the FIR MAC frame sequencer: default frame geometry,
// derived counter widths, grant-slot bounds, the sequencer state encoding and
// a helper used to reject frame geometries that cannot fit a full
// accumulate pass plus one grant window.
package fir_pkg;

  localparam int CLK_DIV = 20;  // clocks per sample frame
  localparam int NUM_TAP = 10;  // MAC steps per frame
  localparam int UPD_CYC = 4;   // clocks per coefficient grant window
  localparam int CNT_W   = 16;  // completed-frame counter width

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TAP_W = 4;
  localparam int UPD_W = $clog2(UPD_CYC + 1);

  // First idle divider slot after DONE, and the last slot from which a full
  // grant window still ends before the next strobe.
  localparam int FIRST_GNT_SLOT = NUM_TAP + 3;
  localparam int LAST_GNT_SLOT  = CLK_DIV - 1 - UPD_CYC;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    DONE,
    UPDATE
  } fir_state_e;

  function automatic bit cfg_ok(int clk_div, int num_tap, int upd_cyc);
    return clk_div >= num_tap + 3 + upd_cyc;
  endfunction

  localparam bit CFG_OK = cfg_ok(CLK_DIV, NUM_TAP, UPD_CYC);

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if
// Control/status bundle between the host side and the frame sequencer.
//   iEnable        run enable (host -> sequencer)
//   iCoeffReq      coefficient write window request, level (host -> sequencer)
//   oEnSample600k  delay-chain shift strobe
//   oAccClr        accumulator clear
//   oMacEn         MAC step enable
//   oTapSel        tap index during MAC
//   oAccDone       result-valid pulse
//   oCoeffGnt      coefficient write window active
//   oBusy          clear/MAC/done in progress
//   oSampleCnt     completed frames
interface fir_mac_sequencer_if;
  import fir_pkg::*;

  logic             iEnable;
  logic             iCoeffReq;
  logic             oEnSample600k;
  logic             oAccClr;
  logic             oMacEn;
  logic [TAP_W-1:0] oTapSel;
  logic             oAccDone;
  logic             oCoeffGnt;
  logic             oBusy;
  logic [CNT_W-1:0] oSampleCnt;

  modport master (
    output iEnable, iCoeffReq,
    input  oEnSample600k, oAccClr, oMacEn, oTapSel, oAccDone,
           oCoeffGnt, oBusy, oSampleCnt
  );

  modport slave (
    input  iEnable, iCoeffReq,
    output oEnSample600k, oAccClr, oMacEn, oTapSel, oAccDone,
           oCoeffGnt, oBusy, oSampleCnt
  );

endinterface

// File: rtl/fir_sample_divider.sv
// fir_sample_divider
// Frame divider: counts 0..CLK_DIV-1 and issues a one-cycle strobe while the
// count is 0. At the frame end (CLK_DIV-1) it parks when the run enable is
// low or while a coefficient grant is still open, so a strobe can never land
// inside a grant window.
//   iClk12M     system clock
//   iRst        async active-high reset
//   run_en      run enable
//   upd_active  sequencer is in its grant window
//   div_cnt     frame position
//   strobe      registered, high exactly while div_cnt == 0
//   held        divider parked at frame end by run_en low
module fir_sample_divider
  import fir_pkg::*;
(
  input  logic             iClk12M,
  input  logic             iRst,
  input  logic             run_en,
  input  logic             upd_active,
  output logic [DIV_W-1:0] div_cnt,
  output logic             strobe,
  output logic             held
);

  logic             at_end;
  logic             hold;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    at_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    hold   = at_end && (!run_en || upd_active);
    held   = at_end && !run_en;
    if (hold) begin
      div_nxt = div_cnt;
    end else if (at_end) begin
      div_nxt = '0;
    end else begin
      div_nxt = div_cnt + 1'b1;
    end
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      div_cnt <= DIV_W'(CLK_DIV - 1);
      strobe  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      strobe  <= (div_nxt == '0);
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Frame scheduler for the FIR delay chain and tap MAC datapath. Each sample
// strobe starts one accumulate pass (clear, NUM_TAP MAC steps, done). Host
// coefficient writes are granted only in idle slots of the frame, or at any
// time while the divider is parked with the run enable low.
//   iClk12M  system clock, 12 MHz
//   iRst     async active-high reset
//   bus      fir_mac_sequencer_if.slave (enable/request in, sequencing out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for the strobe or a legal grant slot
// CLEAR  | one-cycle accumulator clear
// MAC    | NUM_TAP MAC steps, tap index 0..NUM_TAP-1
// DONE   | one-cycle result-valid pulse, frame counter bumps on exit
// UPDATE | coefficient write window, UPD_CYC cycles
module fir_mac_sequencer
  import fir_pkg::*;
(
  input logic               iClk12M,
  input logic               iRst,
  fir_mac_sequencer_if.slave bus
);

  if (!CFG_OK) begin : g_cfg_chk
    $error("fir_pkg: CLK_DIV must be >= NUM_TAP + 3 + UPD_CYC");
  end

  fir_state_e       state;
  logic [DIV_W-1:0] div_cnt;
  logic             strobe;
  logic             held;
  logic             upd_active;
  logic [TAP_W-1:0] tap_cnt;
  logic [UPD_W-1:0] upd_cnt;
  logic             req_pend;
  logic             gnt_used;
  logic             req_any;
  logic             in_slot;
  logic             gnt_ok;
  logic             acc_clr;
  logic             mac_en;
  logic             acc_done;
  logic             coeff_gnt;
  logic             busy;
  logic [CNT_W-1:0] sample_cnt;

  assign upd_active = (state == UPDATE);

  fir_sample_divider u_div (
    .iClk12M    (iClk12M),
    .iRst       (iRst),
    .run_en     (bus.iEnable),
    .upd_active (upd_active),
    .div_cnt    (div_cnt),
    .strobe     (strobe),
    .held       (held)
  );

  // A request seen outside a legal slot is remembered so a short pulse that
  // arrives too late in the frame is served at the first slot of the next.
  assign req_any = bus.iCoeffReq | req_pend;
  assign in_slot = (div_cnt >= DIV_W'(FIRST_GNT_SLOT)) &&
                   (div_cnt <= DIV_W'(LAST_GNT_SLOT)) && !gnt_used;
  assign gnt_ok  = req_any && (in_slot || held);

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      upd_cnt    <= '0;
      req_pend   <= 1'b0;
      gnt_used   <= 1'b0;
      acc_clr    <= 1'b0;
      mac_en     <= 1'b0;
      acc_done   <= 1'b0;
      coeff_gnt  <= 1'b0;
      busy       <= 1'b0;
      sample_cnt <= '0;
    end else begin
      acc_clr   <= 1'b0;
      mac_en    <= 1'b0;
      acc_done  <= 1'b0;
      coeff_gnt <= 1'b0;
      busy      <= 1'b0;

      if (strobe) begin
        gnt_used <= 1'b0;
      end
      // Requests held through a grant window are not latched, so dropping
      // the request during its own window leaves nothing pending.
      if (bus.iCoeffReq && state != UPDATE) begin
        req_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (strobe) begin
            state   <= CLEAR;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end else if (gnt_ok) begin
            state     <= UPDATE;
            upd_cnt   <= UPD_W'(UPD_CYC - 1);
            coeff_gnt <= 1'b1;
            req_pend  <= 1'b0;
            gnt_used  <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= MAC;
          tap_cnt <= '0;
          mac_en  <= 1'b1;
          busy    <= 1'b1;
        end
        MAC: begin
          busy <= 1'b1;
          if (tap_cnt == TAP_W'(NUM_TAP - 1)) begin
            state    <= DONE;
            tap_cnt  <= '0;
            acc_done <= 1'b1;
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
            mac_en  <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          sample_cnt <= sample_cnt + 1'b1;
        end
        UPDATE: begin
          if (upd_cnt == '0) begin
            state <= IDLE;
          end else begin
            upd_cnt   <= upd_cnt - 1'b1;
            coeff_gnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oEnSample600k = strobe;
  assign bus.oAccClr       = acc_clr;
  assign bus.oMacEn        = mac_en;
  assign bus.oTapSel       = tap_cnt;
  assign bus.oAccDone      = acc_done;
  assign bus.oCoeffGnt     = coeff_gnt;
  assign bus.oBusy         = busy;
  assign bus.oSampleCnt    = sample_cnt;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
// Scoreboard bench: the stimulus process pushes the expected output events
// (strobe, clear, MAC step, done, grant cycle) with their absolute cycle
// numbers; the monitor compares whatever the DUT presents each cycle.
module tb_fir_mac_sequencer;

  localparam int K_STROBE = 1;
  localparam int K_CLR    = 2;
  localparam int K_MAC    = 3;
  localparam int K_DONE   = 4;
  localparam int K_GNT    = 5;
  localparam int NTAP     = 10;
  localparam int FRAME    = 20;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc  = 0;
  int   vecs = 0;
  int   errs = 0;
  exp_t exp_q[$];

  fir_mac_sequencer_if bus();

  fir_mac_sequencer dut (
    .iClk12M (clk),
    .iRst    (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void push(int kind, int c, int v);
    exp_t e;
    int   i;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > c) i--;
    exp_q.insert(i, e);
  endfunction

  // Frame starting with strobe at cycle s, frame index k; ntap < NTAP models
  // a frame cut short by reset (no DONE).
  function automatic void push_frame(int s, int k, int ntap);
    push(K_STROBE, s, k);
    push(K_CLR, s + 1, 0);
    for (int i = 0; i < ntap; i++) push(K_MAC, s + 2 + i, i);
    if (ntap == NTAP) push(K_DONE, s + 12, k);
  endfunction

  function automatic void push_gnt(int c0);
    for (int i = 0; i < 4; i++) push(K_GNT, c0 + i, 0);
  endfunction

  task automatic at_cycle(int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    int   obs;
    int   val;
    int   nact;
    exp_t e;
    if (!rst) begin
      nact = int'(bus.oEnSample600k) + int'(bus.oAccClr) + int'(bus.oMacEn) +
             int'(bus.oAccDone) + int'(bus.oCoeffGnt);
      if (nact > 1) chk("one_event", nact, 1);
      obs = 0;
      val = 0;
      if (bus.oEnSample600k) begin
        obs = K_STROBE;
        val = int'(bus.oSampleCnt);
      end else if (bus.oAccClr) begin
        obs = K_CLR;
      end else if (bus.oMacEn) begin
        obs = K_MAC;
        val = int'(bus.oTapSel);
      end else if (bus.oAccDone) begin
        obs = K_DONE;
        val = int'(bus.oSampleCnt);
      end else if (bus.oCoeffGnt) begin
        obs = K_GNT;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        vecs++;
        errs++;
        $display("FAIL missing event @cyc %0d: got none, want kind %0d", e.cyc, e.kind);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("event_kind", obs, e.kind);
        if (e.kind inside {K_STROBE, K_MAC, K_DONE}) chk("event_val", val, e.val);
        chk("busy", int'(bus.oBusy), (e.kind inside {K_CLR, K_MAC, K_DONE}) ? 1 : 0);
        if (e.kind != K_MAC) chk("tap_idle", int'(bus.oTapSel), 0);
      end else if (obs != 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected event @cyc %0d: got kind %0d, want none", cyc, obs);
      end
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_strobe"}, int'(bus.oEnSample600k), 0);
    chk({tag, "_clr"},    int'(bus.oAccClr), 0);
    chk({tag, "_mac"},    int'(bus.oMacEn), 0);
    chk({tag, "_tap"},    int'(bus.oTapSel), 0);
    chk({tag, "_done"},   int'(bus.oAccDone), 0);
    chk({tag, "_gnt"},    int'(bus.oCoeffGnt), 0);
    chk({tag, "_busy"},   int'(bus.oBusy), 0);
    chk({tag, "_cnt"},    int'(bus.oSampleCnt), 0);
  endtask

  initial begin : stim
    exp_t e;
    int   r;
    int   s16;
    int   h;
    int   s17;
    int   s18;
    int   r2;

    bus.iEnable   = 1'b1;
    bus.iCoeffReq = 1'b0;

    at_cycle(3);
    chk_all_zero("reset");
    #1 rst = 1'b0;

    // First strobe in the first cycle after release; frames every 20 clocks.
    r = 4;
    for (int k = 0; k <= 16; k++) push_frame(r + FRAME * k, k, NTAP);
    // Frame 10: req pulse at divCnt 14 -> grant divCnt 15..18.
    push_gnt(r + FRAME * 10 + 15);
    // Frame 11: req pulse at divCnt 17 -> deferred to divCnt 14..17 of frame 12.
    push_gnt(r + FRAME * 12 + 14);
    // Frames 13..15: req held -> one grant per frame at divCnt 14..17.
    push_gnt(r + FRAME * 13 + 14);
    push_gnt(r + FRAME * 14 + 14);
    push_gnt(r + FRAME * 15 + 14);
    // Frame 16: enable dropped at divCnt 5, divider parks at 19 from s16+19.
    s16 = r + FRAME * 16;
    h   = s16 + 25;
    push_gnt(h + 1);
    // Enable returns during the grant; strobe one cycle after it ends.
    s17 = h + 6;
    push_frame(s17, 17, NTAP);
    // Frame 18 is cut by reset during tap 4.
    s18 = s17 + FRAME;
    push_frame(s18, 18, 5);

    at_cycle(r + FRAME * 10 + 14);
    bus.iCoeffReq = 1'b1;
    at_cycle(r + FRAME * 10 + 15);
    bus.iCoeffReq = 1'b0;

    at_cycle(r + FRAME * 11 + 17);
    bus.iCoeffReq = 1'b1;
    at_cycle(r + FRAME * 11 + 18);
    bus.iCoeffReq = 1'b0;

    at_cycle(r + FRAME * 13 + 5);
    bus.iCoeffReq = 1'b1;
    at_cycle(r + FRAME * 15 + 15);
    bus.iCoeffReq = 1'b0;

    at_cycle(s16 + 5);
    bus.iEnable = 1'b0;
    at_cycle(h);
    bus.iCoeffReq = 1'b1;
    at_cycle(h + 1);
    bus.iCoeffReq = 1'b0;
    at_cycle(h + 2);
    bus.iEnable = 1'b1;

    at_cycle(s18 + 6);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");

    at_cycle(s18 + 9);
    rst = 1'b0;
    r2 = s18 + 10;
    push_frame(r2, 0, NTAP);
    push_frame(r2 + FRAME, 1, NTAP);

    at_cycle(r2 + 38);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vecs++;
      errs++;
      $display("FAIL leftover event @cyc %0d: got none, want kind %0d", e.cyc, e.kind);
    end
    chk("final_cnt", int'(bus.oSampleCnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Frame scheduler for the FIR delay chain and tap MAC datapath. It divides the 12 MHz clock into a 600 kHz sample strobe that shifts the delay chain. After each shift it steps a tap index through one accumulate pass with clear, MAC and done phases. It also arbitrates coefficient-memory write access for a host, granting only in idle slots so coefficients never change mid-accumulation.

Parameters:
CLK_DIV, 20, clocks per sample frame (12 MHz / 20 = 600 kHz); must be >= NUM_TAP + 3 + UPD_CYC
NUM_TAP, 10, MAC steps per frame (taps per delay segment)
UPD_CYC, 4, length in clocks of one coefficient-update grant window
CNT_W, 16, width of sample counter

Ports:
iClk12M  in  1  system clock, 12 MHz
iRst  in  1  reset, asynchronous, active-high
iEnable  in  1  run enable; low holds the divider at frame end
iCoeffReq  in  1  host request for coefficient write window (level)
oEnSample600k  out  1  one-cycle sample strobe to delay chain
oAccClr  out  1  one-cycle accumulator clear
oMacEn  out  1  MAC step enable
oTapSel  out  4  tap index 0..NUM_TAP-1 during MAC
oAccDone  out  1  one-cycle result-valid pulse
oCoeffGnt  out  1  coefficient write window active
oBusy  out  1  high in CLEAR, MAC or DONE
oSampleCnt  out  CNT_W  completed frames, wraps

Behaviour:
- Reset: divCnt = CLK_DIV-1, state IDLE, tapCnt 0. All outputs 0, oSampleCnt 0. Async assert, sync release.
- All outputs are decoded from registers only, with no input-to-output combinational paths.
- Divider: divCnt counts 0..CLK_DIV-1 and wraps. At divCnt = CLK_DIV-1 with iEnable=0, or with state UPDATE, it holds. oEnSample600k=1 exactly in cycles where divCnt=0.
- States: IDLE, CLEAR, MAC, DONE, UPDATE.
- IDLE -> CLEAR on the edge ending the strobe cycle (divCnt 0). CLEAR lasts 1 cycle with oAccClr=1 (divCnt 1).
- MAC lasts NUM_TAP cycles (divCnt 2..NUM_TAP+1). oMacEn=1 and oTapSel=0,1,..,NUM_TAP-1 in order. oTapSel is 0 outside MAC.
- DONE lasts 1 cycle (divCnt NUM_TAP+2) with oAccDone=1. oSampleCnt increments on exit (wraps at 2^CNT_W). Then IDLE.
- Grant rule: IDLE -> UPDATE on an edge where iCoeffReq=1 and either (divCnt <= CLK_DIV-1-UPD_CYC and divCnt > NUM_TAP+2) or the divider is held by iEnable=0. At most one grant per frame while running.
- UPDATE: oCoeffGnt=1 for exactly UPD_CYC cycles, then IDLE regardless of iCoeffReq. A still-high req is considered again under the grant rule.
- Late request (after the last legal slot): deferred. The grant starts at the first IDLE cycle of the next frame (divCnt NUM_TAP+3 decision, gnt from NUM_TAP+4).
- Strobe and grant never overlap by construction. If iEnable rises during UPDATE, the strobe waits until UPDATE ends.
- iEnable falling mid-frame: the current CLEAR/MAC/DONE sequence completes. The divider then holds at CLK_DIV-1 and no further strobe is issued. The first strobe comes one cycle after iEnable is seen high at the hold point.
- Reset mid-frame: immediate abort to reset values. No oAccDone pulse is issued for the partial frame.

Decomposition:
- Shared package fir_pkg holds the state enum (IDLE, CLEAR, MAC, DONE, UPDATE) and the defaults CLK_DIV, NUM_TAP, UPD_CYC.
- The same package holds a derived constant LAST_GNT_SLOT = CLK_DIV-1-UPD_CYC, plus an elaboration check that CLK_DIV >= NUM_TAP+3+UPD_CYC.
- Sub-module fir_sample_divider holds the divider counter, hold logic and strobe. FSM and arbitration stay in the top module.

Test Plan:
- Reset release with iEnable=1 -> oEnSample600k on the 1st cycle, then every 20 cycles. After 10 frames, oSampleCnt=10.
- Single frame timing -> oAccClr at strobe+1, oMacEn with oTapSel 0..9 at strobe+2..+11, oAccDone at strobe+12, oBusy high strobe+1..+12.
- iCoeffReq pulses at divCnt 14 -> oCoeffGnt high divCnt 15..18, no overlap with the strobe at divCnt 0. A req held high through several frames -> exactly one 4-cycle grant per frame.
- iCoeffReq at divCnt 17 -> no grant that frame; grant at divCnt 14..17 of the next frame.
- iEnable dropped at divCnt 5 -> frame finishes with oAccDone at divCnt 12, then no strobe. A req while held -> immediate 4-cycle grant. iEnable high again -> strobe one cycle later (after any grant ends).
- iRst asserted during MAC (tap 4) -> all outputs 0 asynchronously, no oAccDone, oSampleCnt=0. Restart timing is identical to the first scenario.
